// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the cache line refill path.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } fill_state_e;

  localparam int DEF_LINE_SIZE_BYTES = 4;
  localparam int DEF_WAYS            = 4;
  localparam int DEF_BEAT_BYTES      = 1;

  function automatic int calc_beats(input int line_bytes, input int beat_bytes);
    return line_bytes / beat_bytes;
  endfunction

  // Beat counter needs at least one bit even for a single-beat line.
  function automatic int calc_cnt_w(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/way_sel_decode.sv
// Priority decode of a victim-way select to one-hot (highest set bit wins),
// plus a flag telling whether the raw select was already exactly one-hot.
module way_sel_decode #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-1:0] sel,
  output logic [WAYS-1:0] onehot,
  output logic            is_onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (sel[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign is_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

endmodule

// File: rtl/cache_line_fill.sv
// Refill line assembler: collects beats into a line buffer, then writes one way.
// Optional build macro CACHE_FILL_ONEHOT_CHECK_EN rejects non-one-hot way selects.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a fill start; beats not accepted
// COLLECT | accepting beats into the line buffer
// WRITE   | one-cycle write of the buffer into the latched way, done pulse
module cache_line_fill
  import cache_pkg::*;
#(
  parameter int LINE_SIZE_BYTES = DEF_LINE_SIZE_BYTES,
  parameter int WAYS            = DEF_WAYS,
  parameter int BEAT_BYTES      = DEF_BEAT_BYTES
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_fill_start,
  input  logic [WAYS-1:0]              i_way_sel,
  input  logic                         i_beat_valid,
  input  logic [BEAT_BYTES*8-1:0]      i_beat_data,
  output logic                         o_beat_ready,
  output logic [WAYS-1:0]              o_way_we,
  output logic [LINE_SIZE_BYTES*8-1:0] o_way_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int BEATS  = calc_beats(LINE_SIZE_BYTES, BEAT_BYTES);
  localparam int CNT_W  = calc_cnt_w(BEATS);
  localparam int BEAT_W = BEAT_BYTES * 8;
  localparam int LINE_W = LINE_SIZE_BYTES * 8;

  fill_state_e       state_q, state_d;
  logic [WAYS-1:0]   way_q;
  logic [WAYS-1:0]   dec_onehot;
  logic              dec_is_onehot;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              start_ok;
  logic              start_bad;
  logic              beat_hs;
  logic              last_beat;

  way_sel_decode #(.WAYS(WAYS)) u_dec (
    .sel       (i_way_sel),
    .onehot    (dec_onehot),
    .is_onehot (dec_is_onehot)
  );

`ifdef CACHE_FILL_ONEHOT_CHECK_EN
  assign start_ok  = i_fill_start & dec_is_onehot;
  assign start_bad = i_fill_start & ~dec_is_onehot;
`else
  logic unused_is_onehot;
  assign unused_is_onehot = dec_is_onehot;
  assign start_ok  = i_fill_start;
  assign start_bad = 1'b0;
`endif

  assign beat_hs   = (state_q == ST_COLLECT) && i_beat_valid;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_ok) state_d = ST_COLLECT;
      ST_COLLECT: if (beat_hs && last_beat) state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      way_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          err_q <= start_bad;
          if (start_ok) begin
            way_q  <= dec_onehot;
            line_q <= '0;
            cnt_q  <= '0;
          end
        end
        ST_COLLECT: begin
          if (beat_hs) begin
            line_q[BEAT_W*int'(cnt_q) +: BEAT_W] <= i_beat_data;
            // Hold on the last beat so the counter never wraps within a fill.
            if (!last_beat) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_beat_ready = (state_q == ST_COLLECT);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_WRITE);
  assign o_way_we     = (state_q == ST_WRITE) ? way_q : '0;
  assign o_way_data   = line_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: expected writes are queued at fill start
// and matched against the DUT's write/done cycle.
module tb_cache_line_fill;

  localparam int LB    = 4;
  localparam int WAYS  = 4;
  localparam int BB    = 1;
  localparam int BEATS = LB / BB;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_fill_start;
  logic [WAYS-1:0]   i_way_sel;
  logic              i_beat_valid;
  logic [BB*8-1:0]   i_beat_data;
  logic              o_beat_ready;
  logic [WAYS-1:0]   o_way_we;
  logic [LB*8-1:0]   o_way_data;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  cache_line_fill #(.LINE_SIZE_BYTES(LB), .WAYS(WAYS), .BEAT_BYTES(BB)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_fill_start (i_fill_start),
    .i_way_sel    (i_way_sel),
    .i_beat_valid (i_beat_valid),
    .i_beat_data  (i_beat_data),
    .o_beat_ready (o_beat_ready),
    .o_way_we     (o_way_we),
    .o_way_data   (o_way_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [WAYS-1:0] we;
    logic [LB*8-1:0] data;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst === 1'b0) begin
      if (o_done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 64'(o_done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("way_we", 64'(o_way_we), 64'(e.we));
          chk("way_data", 64'(o_way_data), 64'(e.data));
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (o_way_we != '0) begin
        chk("we_without_done", 64'(o_way_we), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_fill(input logic [WAYS-1:0] sel, input logic [WAYS-1:0] exp_we,
                         input logic [LB*8-1:0] line, input int stall_after,
                         input int stall_n, input bit intrude);
    exp_t x;
    step();
    i_fill_start = 1'b1;
    i_way_sel    = sel;
    x.we   = exp_we;
    x.data = line;
    x.cyc  = cyc + 1 + BEATS + stall_n;
    sb.push_back(x);
    step();
    i_fill_start = intrude;
    if (intrude) i_way_sel = 4'b0001;
    for (int b = 0; b < BEATS; b++) begin
      i_beat_valid = 1'b1;
      i_beat_data  = line[b*8 +: 8];
      chk("busy_collect", 64'(o_busy), 64'd1);
      chk("ready_collect", 64'(o_beat_ready), 64'd1);
      step();
      if (b == stall_after) begin
        for (int s = 0; s < stall_n; s++) begin
          i_beat_valid = 1'b0;
          i_beat_data  = 8'hEE;
          chk("ready_stall", 64'(o_beat_ready), 64'd1);
          step();
        end
      end
    end
    i_beat_valid = 1'b0;
    i_fill_start = 1'b0;
    chk("busy_write", 64'(o_busy), 64'd1);
    chk("ready_write", 64'(o_beat_ready), 64'd0);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge i_clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
    chk("busy_after", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst        = 1'b1;
    i_fill_start = 1'b0;
    i_way_sel    = '0;
    i_beat_valid = 1'b0;
    i_beat_data  = '0;
    step();
    step();
    chk("rst_ready", 64'(o_beat_ready), 64'd0);
    chk("rst_we", 64'(o_way_we), 64'd0);
    chk("rst_data", 64'(o_way_data), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    i_rst = 1'b0;

    i_beat_valid = 1'b1;
    i_beat_data  = 8'h99;
    step();
    chk("idle_ready", 64'(o_beat_ready), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    i_beat_valid = 1'b0;

    do_fill(4'b0100, 4'b0100, 32'h44332211, -1, 0, 1'b0);
    do_fill(4'b0100, 4'b0100, 32'h44332211, 1, 3, 1'b0);
    do_fill(4'b0100, 4'b0100, 32'h8877_6655, -1, 0, 1'b1);

    // Abort a fill with reset after two beats.
    step();
    i_fill_start = 1'b1;
    i_way_sel    = 4'b0100;
    step();
    i_fill_start = 1'b0;
    i_beat_valid = 1'b1;
    i_beat_data  = 8'h55;
    step();
    i_beat_data  = 8'h66;
    step();
    i_beat_valid = 1'b0;
    i_rst        = 1'b1;
    step();
    chk("abort_ready", 64'(o_beat_ready), 64'd0);
    chk("abort_we", 64'(o_way_we), 64'd0);
    chk("abort_data", 64'(o_way_data), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_done", 64'(o_done), 64'd0);
    chk("abort_err", 64'(o_err), 64'd0);
    i_rst = 1'b0;
    do_fill(4'b1000, 4'b1000, 32'hA3A2A1A0, -1, 0, 1'b0);

`ifdef CACHE_FILL_ONEHOT_CHECK_EN
    step();
    i_fill_start = 1'b1;
    i_way_sel    = 4'b0110;
    step();
    i_fill_start = 1'b0;
    chk("err_pulse", 64'(o_err), 64'd1);
    chk("err_busy", 64'(o_busy), 64'd0);
    chk("err_ready", 64'(o_beat_ready), 64'd0);
    step();
    chk("err_clear", 64'(o_err), 64'd0);
    chk("err_busy2", 64'(o_busy), 64'd0);
    do_fill(4'b0010, 4'b0010, 32'hC3C2C1C0, -1, 0, 1'b0);
`else
    do_fill(4'b0110, 4'b0100, 32'hB3B2B1B0, -1, 0, 1'b0);
    do_fill(4'b0000, 4'b0000, 32'hD3D2D1D0, 2, 1, 1'b0);
    chk("err_tied", 64'(o_err), 64'd0);
`endif

    do_fill(4'b0001, 4'b0001, 32'h0F1E2D3C, 0, 2, 1'b0);
    step();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
